// File: rtl/tetris_display_ctrl.sv
// ============================================================================
// tetris_display_ctrl
// ----------------------------------------------------------------------------
// Game-state sequencer and layer compositor for the Tetris video path.
//
// Holds the game state (IDLE/PLAY/PAUSE/OVER). Control requests are latched
// into pending flags and only acted on at a frame boundary (x,y)=(0,0), so
// the state never changes in the middle of a frame. Three overlay layers
// (frame outline, board, next-block box) are gated by the state and merged
// by priority into one registered RGB/dav stream.
//
// Optional feature macro: PAUSE_DIM_EN
//   defined   : in PAUSE the board layer stays visible at half intensity
//   undefined : in PAUSE the board layer is hidden
//
// Parameters:
//   H_ACTIVE      active pixels per line (x >= H_ACTIVE is blank)
//   V_ACTIVE      active lines per frame (y >= V_ACTIVE is blank)
//   BLINK_FRAMES  frames per blink half-period in OVER (1..255)
//
// Ports:
//   i_pixclk                 pixel clock, all logic on rising edge
//   i_reset                  synchronous active-high reset
//   i_cnt_x, i_cnt_y  [11:0] current pixel column / row
//   i_start                  start/restart request (level, per cycle)
//   i_pause                  pause-toggle request (level, per cycle)
//   i_game_over              game-over request
//   i_frm_r/g/b, i_frm_dav   frame-outline layer (lowest priority)
//   i_brd_r/g/b, i_brd_dav   board layer
//   i_nxt_r/g/b, i_nxt_dav   next-block layer (highest priority)
//   o_game_state      [1:0]  0=IDLE 1=PLAY 2=PAUSE 3=OVER
//   o_frame_start            pulse one cycle after (0,0) is sampled
//   o_r, o_g, o_b     [7:0]  composited colour
//   o_dav                    composited pixel valid
// ============================================================================
module tetris_display_ctrl #(
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        i_pixclk,
    input  logic        i_reset,
    input  logic [11:0] i_cnt_x,
    input  logic [11:0] i_cnt_y,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_game_over,
    input  logic [7:0]  i_frm_r,
    input  logic [7:0]  i_frm_g,
    input  logic [7:0]  i_frm_b,
    input  logic        i_frm_dav,
    input  logic [7:0]  i_brd_r,
    input  logic [7:0]  i_brd_g,
    input  logic [7:0]  i_brd_b,
    input  logic        i_brd_dav,
    input  logic [7:0]  i_nxt_r,
    input  logic [7:0]  i_nxt_g,
    input  logic [7:0]  i_nxt_b,
    input  logic        i_nxt_dav,
    output logic [1:0]  o_game_state,
    output logic        o_frame_start,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_dav
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [11:0] H_LIM      = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM      = 12'(V_ACTIVE);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        start_p_q, start_p_d;
    logic        pause_p_q, pause_p_d;
    logic        over_p_q, over_p_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic        frame_start_q;
    logic [23:0] rgb_q, rgb_d;
    logic        dav_q, dav_d;

    logic        fs;
    logic        active;
    logic [2:0]  layer_en;
    logic [2:0]  layer_dav;
    logic [2:0]  layer_hit;
    logic [23:0] layer_rgb [3];
    logic [23:0] brd_rgb;

    assign fs     = (i_cnt_x == 12'd0) && (i_cnt_y == 12'd0);
    assign active = (i_cnt_x < H_LIM) && (i_cnt_y < V_LIM);

    // ------------------------------------------------------------------
    // State register (also pending flags, blink, output pipeline)
    // ------------------------------------------------------------------
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            start_p_q     <= 1'b0;
            pause_p_q     <= 1'b0;
            over_p_q      <= 1'b0;
            blink_cnt_q   <= 8'd0;
            phase_q       <= 1'b1;
            frame_start_q <= 1'b0;
            rgb_q         <= 24'd0;
            dav_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_p_q     <= start_p_d;
            pause_p_q     <= pause_p_d;
            over_p_q      <= over_p_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            frame_start_q <= fs;
            rgb_q         <= rgb_d;
            dav_q         <= dav_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (fs) begin
            case (state_q)
                ST_IDLE:  if (start_p_q) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (over_p_q)       state_d = ST_OVER;
                    else if (pause_p_q) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (over_p_q)       state_d = ST_OVER;
                    else if (pause_p_q) state_d = ST_PLAY;
                end
                ST_OVER:  if (start_p_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        // At FS the flags are consumed; the FS cycle's own request is the
        // only thing carried into the new frame.
        start_p_d = fs ? i_start     : (start_p_q | i_start);
        pause_p_d = fs ? i_pause     : (pause_p_q | i_pause);
        over_p_d  = fs ? i_game_over : (over_p_q  | i_game_over);

        // Blink: idle at (0, visible) unless we stay in OVER across an FS.
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_d != ST_OVER || state_q != ST_OVER) begin
            blink_cnt_d = 8'd0;
            phase_d     = 1'b1;
        end else if (fs) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic: layer enables follow the *next* state so the FS pixel
    // already uses the state that becomes visible on that edge.
    // Bit index = layer number (0 frame, 1 board, 2 next).
    // ------------------------------------------------------------------
    always_comb begin
        layer_en = 3'b000;
        brd_rgb  = {i_brd_r, i_brd_g, i_brd_b};
        case (state_d)
            ST_IDLE:  layer_en = 3'b001;
            ST_PLAY:  layer_en = 3'b111;
            ST_PAUSE: begin
`ifdef PAUSE_DIM_EN
                layer_en = 3'b111;
                brd_rgb  = {1'b0, i_brd_r[7:1], 1'b0, i_brd_g[7:1], 1'b0, i_brd_b[7:1]};
`else
                layer_en = 3'b101;
`endif
            end
            ST_OVER:  layer_en = {1'b1, phase_d, 1'b1};
            default:  layer_en = 3'b000;
        endcase
    end

    assign layer_rgb[0] = {i_frm_r, i_frm_g, i_frm_b};
    assign layer_rgb[1] = brd_rgb;
    assign layer_rgb[2] = {i_nxt_r, i_nxt_g, i_nxt_b};
    assign layer_dav    = {i_nxt_dav, i_brd_dav, i_frm_dav};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hit
            assign layer_hit[gi] = layer_en[gi] & layer_dav[gi];
        end
    endgenerate

    // Priority merge: next > board > frame; blank or no winner gives black.
    always_comb begin
        rgb_d = 24'd0;
        dav_d = 1'b0;
        if (active) begin
            if (layer_hit[2]) begin
                rgb_d = layer_rgb[2];
                dav_d = 1'b1;
            end else if (layer_hit[1]) begin
                rgb_d = layer_rgb[1];
                dav_d = 1'b1;
            end else if (layer_hit[0]) begin
                rgb_d = layer_rgb[0];
                dav_d = 1'b1;
            end
        end
    end

    assign o_game_state  = state_q;
    assign o_frame_start = frame_start_q;
    assign o_r           = rgb_q[23:16];
    assign o_g           = rgb_q[15:8];
    assign o_b           = rgb_q[7:0];
    assign o_dav         = dav_q;

endmodule

// File: doc/tetris_display_ctrl.md
# tetris_display_ctrl

Game-state sequencer and layer compositor for the Tetris video path. It holds the game state (IDLE/PLAY/PAUSE/OVER) and applies control requests only at frame boundaries, so state never changes mid-frame. It gates and merges the three overlay layers (frame outline, board, next-block box) into one registered RGB/dav stream for the HDMI/VGA encoder. It is driven by the same pixel counters as the layer renderers.

## Interface
- H_ACTIVE, 1024, active pixels per line; pixels with x >= H_ACTIVE are blank
- V_ACTIVE, 768, active lines per frame; lines with y >= V_ACTIVE are blank
- BLINK_FRAMES, 30, frames per blink half-period in OVER (1..255)

Ports:
- i_pixclk  in  1  pixel clock; all logic is on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cnt_x  in  12  current pixel column
- i_cnt_y  in  12  current pixel row
- i_start  in  1  start/restart request, level sampled per cycle
- i_pause  in  1  pause-toggle request, level sampled per cycle
- i_game_over  in  1  game-over request from game logic
- i_frm_r/g/b, i_frm_dav  in  8/8/8/1  frame-outline layer (layer 0, lowest priority)
- i_brd_r/g/b, i_brd_dav  in  8/8/8/1  board layer (layer 1)
- i_nxt_r/g/b, i_nxt_dav  in  8/8/8/1  next-block layer (layer 2, highest priority)
- o_game_state  out  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER
- o_frame_start  out  1  one-cycle pulse in the cycle after (x,y)=(0,0) is sampled
- o_r/o_g/o_b  out  8 each  composited colour
- o_dav  out  1  composited pixel valid

## Operation
- Frame-start event (FS): i_cnt_x==0 && i_cnt_y==0 is sampled in a cycle. o_frame_start is its registered version.
- Pending flags start_p, pause_p, over_p are set by any cycle with the matching input high.
- Transitions are evaluated on FS from the registered pending flags only. After evaluation, all pending flags clear, so unused requests are discarded. A request high in the FS cycle itself is kept and applied at the next FS.
- At FS, the first matching rule applies:
  - IDLE: start_p -> PLAY
  - PLAY: over_p -> OVER; else pause_p -> PAUSE
  - PAUSE: over_p -> OVER; else pause_p -> PLAY; start_p is ignored
  - OVER: start_p -> IDLE
- Blink: an 8-bit frame counter and a phase bit.
  - Entry to OVER sets counter=0 and phase=1 (visible).
  - In OVER, each FS increments the counter. When the counter reaches BLINK_FRAMES-1, it wraps to 0 and phase toggles.
  - Outside OVER, counter=0 and phase=1.
- Layer enables by state:
  - IDLE: frame only
  - PLAY: all layers
  - PAUSE: frame and next; board per Configuration
  - OVER: frame and next; board only when phase=1
- Compositing: highest-priority enabled layer with dav=1 wins (next > board > frame).
- If no layer wins, or the pixel is outside the active area: o_dav=0, o_r/g/b=0.

## Timing
- Reset values: o_game_state=0 (IDLE), o_frame_start=0, o_r/g/b=0, o_dav=0, pending flags 0, blink counter 0, phase 1.
- Reset asserted mid-frame takes effect the next edge. The first transition after reset needs a fresh FS.
- Pixel latency: 1 cycle. Inputs (x,y,layers) sampled at edge N appear on o_r/g/b/o_dav after edge N.
- o_game_state updates on the FS edge, coincident with o_frame_start=1. The FS pixel is composited using the new state's enables.
- Layer inputs must be aligned with i_cnt_x/i_cnt_y in the same cycle.
- No handshake: requests are fire-and-forget. Any pulse of at least 1 cycle is captured.

## Configuration
- PAUSE_DIM_EN defined: in PAUSE the board layer stays enabled and its colour channels are right-shifted by 1 (half intensity). Priority is unchanged.
- PAUSE_DIM_EN undefined: in PAUSE the board layer is disabled.

## Test plan
- Reset, then i_start pulsed at (x=500,y=300) -> o_game_state stays 0 until next FS, then 1 with o_frame_start=1. Idle-state board dav at (500,300) yields o_dav=0.
- PLAY with i_pause and i_game_over both pulsed in the same frame -> next FS gives state 3. A second FS without requests keeps 3.
- i_start high exactly in the FS cycle while IDLE -> state stays 0 at that FS and becomes 1 at the following FS.
- Overlap at (700,300): frm=FF0000, brd=00FF00, nxt=0000FF, all dav=1 -> one cycle later o_r/g/b=00/00/FF, o_dav=1. With nxt_dav=0 -> 00/FF/00. At x=1030 -> o_dav=0, rgb=0.
- OVER with BLINK_FRAMES=2 and board-only pixel -> board visible for frames 0-1, hidden for frames 2-3, visible again for frames 4-5. i_start then returns the state to IDLE.
- PAUSE with brd=80C0FE on a board-only pixel -> with PAUSE_DIM_EN: output 40607F, dav=1; without it: dav=0.
